// File: rtl/fft_1d_8_in_buf.sv
// fft_1d_8_in_buf: ping-pong serial-to-parallel frame buffer in front of the 8-point FFT core.
// Optional start-of-frame resync enabled by defining FFT_IN_SOF_EN.
module fft_1d_8_in_buf #(
   parameter int DATA_W = 16,
   parameter int CNT_W  = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [DATA_W-1:0]     s_r,
   input  logic [DATA_W-1:0]     s_i,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [8*DATA_W-1:0]   par_r,
   output logic [8*DATA_W-1:0]   par_i,
   output logic [CNT_W-1:0]      frm_cnt
`ifdef FFT_IN_SOF_EN
   ,
   input  logic                  s_sof,
   output logic                  sof_err
`endif
);
   logic [DATA_W-1:0] mem_r [2][8];
   logic [DATA_W-1:0] mem_i [2][8];
   logic [1:0] full, set_m, clr_m;
   logic wr_bank, rd_bank, wr, rd, sof_rst, last;
   logic [2:0] wr_idx, idx;
   assign s_ready = !full[wr_bank];
   assign m_valid = full[rd_bank];
   assign wr = s_valid && s_ready;
   assign rd = m_valid && m_ready;
`ifdef FFT_IN_SOF_EN
   assign sof_rst = wr && s_sof && wr_idx != 3'd0;
`else
   assign sof_rst = 1'b0;
`endif
   // a resync restarts the frame at slot 0, so it can never complete one
   assign idx   = sof_rst ? 3'd0 : wr_idx;
   assign last  = wr && !sof_rst && wr_idx == 3'd7;
   assign set_m = last ? (wr_bank ? 2'b10 : 2'b01) : 2'b00;
   assign clr_m = rd ? (rd_bank ? 2'b10 : 2'b01) : 2'b00;
   always_comb begin
      par_r = '0;
      par_i = '0;
      for (int k = 0; k < 8; k++) begin
         par_r[k*DATA_W +: DATA_W] = mem_r[rd_bank][k];
         par_i[k*DATA_W +: DATA_W] = mem_i[rd_bank][k];
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int b = 0; b < 2; b++)
            for (int k = 0; k < 8; k++) begin
               mem_r[b][k] <= '0;
               mem_i[b][k] <= '0;
            end
         full    <= 2'b00;
         wr_bank <= 1'b0;
         rd_bank <= 1'b0;
         wr_idx  <= 3'd0;
         frm_cnt <= '0;
      end else begin
         // set and clear always hit different banks, so both may apply at once
         full <= (full | set_m) & ~clr_m;
         if (wr) begin
            mem_r[wr_bank][idx] <= s_r;
            mem_i[wr_bank][idx] <= s_i;
            wr_idx <= sof_rst ? 3'd1 : wr_idx + 3'd1;
            if (last) wr_bank <= !wr_bank;
         end
         if (rd) begin
            rd_bank <= !rd_bank;
            frm_cnt <= frm_cnt + CNT_W'(1);
         end
      end
   end
`ifdef FFT_IN_SOF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sof_err <= 1'b0;
      else sof_err <= sof_rst;
   end
`endif
endmodule
